burst_rr_arbiter: RTL and testbench

BURST_RR_ARBITER -- requirements
Module: burst_rr_arbiter

---
 rtl/burst_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_burst_rr_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_rr_arbiter.sv
// burst_rr_arbiter: round-robin arbiter that grants one requester a burst of
// LAST_BEAT+1 beats, then rotates priority to the requester after the owner.
// Optional feature macro: ARB_EARLY_RELEASE_EN. When it is defined, an owner
// dropping its request ends the burst early.
module burst_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int LAST_BEAT = 2,
    localparam int GW = $clog2(NUM_REQ),
    localparam int CW = (LAST_BEAT > 0) ? $clog2(LAST_BEAT + 1) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               beat_ready,
    output logic [NUM_REQ-1:0] grant,
    output logic [GW-1:0]      grant_id,
    output logic               beat_valid,
    output logic [CW-1:0]      beat_count,
    output logic               last_beat,
    output logic               burst_done
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    localparam int unsigned          NR       = NUM_REQ;
    localparam logic [CW-1:0]        LAST_CNT = CW'(LAST_BEAT);
    localparam logic [NUM_REQ-1:0]   ONE      = NUM_REQ'(1);

    logic [0:0]    state;
    logic [GW-1:0] ptr;
    logic [GW-1:0] arb_base;
    logic [GW-1:0] sel_id;
    logic [GW-1:0] hi_id;
    logic [GW-1:0] lo_id;
    logic          hi_found;
    logic          lo_found;
    logic          sel_valid;
    logic          busy;
    logic          fire;
    logic          final_beat;
    logic          burst_end;

    assign busy = (state == BURST);

`ifdef ARB_EARLY_RELEASE_EN
    logic owner_req;
    assign owner_req  = req[grant_id];
    assign beat_valid = busy && owner_req;
    // Owner withdrawing its request closes the burst without counting a beat.
    assign burst_end  = final_beat || (busy && !owner_req);
`else
    assign beat_valid = busy;
    assign burst_end  = final_beat;
`endif

    assign fire       = beat_valid && beat_ready;
    assign final_beat = fire && (beat_count == LAST_CNT);
    assign last_beat  = beat_valid && (beat_count == LAST_CNT);

    // At a burst boundary the pointer is about to become the owner, so
    // arbitrate from grant_id directly to avoid an idle cycle.
    assign arb_base = busy ? grant_id : ptr;

    // Round-robin pick: lowest index above arb_base, else lowest index at or below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int unsigned j = 0; j < NR; j++) begin
            if (req[j]) begin
                if (GW'(j) > arb_base) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_id    = GW'(j);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_id    = GW'(j);
                end
            end
        end
        sel_valid = hi_found || lo_found;
        sel_id    = hi_found ? hi_id : lo_id;
    end

    // Burst FSM: grant loading, beat counting, pointer rotation and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            grant_id   <= '0;
            beat_count <= '0;
            burst_done <= 1'b0;
            ptr        <= GW'(NUM_REQ - 1);
        end else begin
            burst_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state      <= BURST;
                        grant      <= ONE << sel_id;
                        grant_id   <= sel_id;
                        beat_count <= '0;
                    end
                end
                BURST: begin
                    if (burst_end) begin
                        ptr        <= grant_id;
                        burst_done <= 1'b1;
                        beat_count <= '0;
                        if (sel_valid) begin
                            grant    <= ONE << sel_id;
                            grant_id <= sel_id;
                        end else begin
                            state    <= IDLE;
                            grant    <= '0;
                            grant_id <= '0;
                        end
                    end else if (fire) begin
                        beat_count <= beat_count + CW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    grant      <= '0;
                    grant_id   <= '0;
                    beat_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Self-checking bench for burst_rr_arbiter: default instance (4 requesters,
// 3-beat bursts) plus a single-beat instance (LAST_BEAT=0).
module tb_burst_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       beat_ready;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       beat_valid;
    logic [1:0] beat_count;
    logic       last_beat;
    logic       burst_done;

    logic [3:0] req2;
    logic       ready2;
    logic [3:0] grant2;
    logic [1:0] grant_id2;
    logic       beat_valid2;
    logic [0:0] beat_count2;
    logic       last_beat2;
    logic       burst_done2;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] id;
        logic       valid;
        logic [1:0] cnt;
        logic       last;
        logic       done;
    } obs_t;

    obs_t       exp_q[$];
    logic [9:0] exp2_q[$];
    int         checks = 0;
    int         passed = 0;

    burst_rr_arbiter #(.NUM_REQ(4), .LAST_BEAT(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .beat_ready (beat_ready),
        .grant      (grant),
        .grant_id   (grant_id),
        .beat_valid (beat_valid),
        .beat_count (beat_count),
        .last_beat  (last_beat),
        .burst_done (burst_done)
    );

    burst_rr_arbiter #(.NUM_REQ(4), .LAST_BEAT(0)) dut1b (
        .clk        (clk),
        .reset      (reset),
        .req        (req2),
        .beat_ready (ready2),
        .grant      (grant2),
        .grant_id   (grant_id2),
        .beat_valid (beat_valid2),
        .beat_count (beat_count2),
        .last_beat  (last_beat2),
        .burst_done (burst_done2)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(logic [3:0] g, logic [1:0] id, logic v,
                                logic [1:0] c, logic l, logic d);
        obs_t o;
        o.grant = g;
        o.id    = id;
        o.valid = v;
        o.cnt   = c;
        o.last  = l;
        o.done  = d;
        return o;
    endfunction

    function automatic obs_t observe();
        return obs_t'({grant, grant_id, beat_valid, beat_count, last_beat, burst_done});
    endfunction

    task automatic do_reset();
        reset      = 1'b1;
        req        = '0;
        req2       = '0;
        beat_ready = 1'b1;
        ready2     = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        obs_t want;
        reset = 1'b1;
        req   = 4'b1111;
        req2  = 4'b0110;
        beat_ready = 1'b1;
        ready2     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        got = observe();
        checks++;
        if (got !== mk(4'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0))
            $display("FAIL reset_state: got %h want %h", got, mk(4'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        else passed++;
        checks++;
        if ({grant2, grant_id2, beat_valid2, beat_count2, last_beat2, burst_done2} !== 10'd0)
            $display("FAIL reset_state_b0: got %h want 000",
                     {grant2, grant_id2, beat_valid2, beat_count2, last_beat2, burst_done2});
        else passed++;
        @(posedge clk);
        #1 reset = 1'b0;
        req  = '0;
        req2 = '0;
        for (int c = 1; c <= 3; c++) begin
            exp_q.push_back(mk(4'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) $display("FAIL idle_no_req c%0d: got %h want %h", c, got, want);
            else passed++;
        end
    endtask

    task automatic test_single_requester();
        obs_t got;
        obs_t want;
        obs_t tbl[8];
        tbl[0] = mk(4'b0001, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        tbl[1] = mk(4'b0001, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
        tbl[2] = mk(4'b0001, 2'd0, 1'b1, 2'd2, 1'b1, 1'b0);
        tbl[3] = mk(4'b0001, 2'd0, 1'b1, 2'd0, 1'b0, 1'b1);
        tbl[4] = mk(4'b0001, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
        tbl[5] = mk(4'b0001, 2'd0, 1'b1, 2'd2, 1'b1, 1'b0);
        tbl[6] = mk(4'b0000, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        tbl[7] = mk(4'b0000, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        do_reset();
        req = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (c >= 5) req = 4'b0000;
            exp_q.push_back(tbl[c-1]);
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) $display("FAIL single_req c%0d: got %h want %h", c, got, want);
            else passed++;
        end
    endtask

    task automatic test_round_robin();
        obs_t got;
        obs_t want;
        int   b;
        int   k;
        logic [1:0] id;
        do_reset();
        req = 4'b1111;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk);
            #1;
            b  = (c - 1) / 3;
            k  = (c - 1) % 3;
            id = 2'(b % 4);
            exp_q.push_back(mk(4'b0001 << id, id, 1'b1, 2'(k), k == 2, (k == 0) && (b > 0)));
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) $display("FAIL round_robin c%0d: got %h want %h", c, got, want);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        obs_t got;
        obs_t want;
        obs_t tbl[7];
        logic rdy[7];
        rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[0] = mk(4'b0001, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        tbl[1] = mk(4'b0001, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
        tbl[2] = mk(4'b0001, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
        tbl[3] = mk(4'b0001, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
        tbl[4] = mk(4'b0001, 2'd0, 1'b1, 2'd2, 1'b1, 1'b0);
        tbl[5] = mk(4'b0000, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        tbl[6] = mk(4'b0000, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        do_reset();
        req = 4'b0001;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            beat_ready = rdy[c-1];
            if (c >= 2) req = 4'b0000;
            exp_q.push_back(tbl[c-1]);
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) $display("FAIL backpressure c%0d: got %h want %h", c, got, want);
            else passed++;
        end
        beat_ready = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        obs_t got;
        obs_t want;
        do_reset();
        req = 4'b0001;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk);
            #1;
            exp_q.push_back(mk(4'b0001, 2'd0, 1'b1, 2'(c - 1), 1'b0, 1'b0));
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) $display("FAIL mid_pre c%0d: got %h want %h", c, got, want);
            else passed++;
        end
        #1 reset = 1'b1;
        exp_q.push_back(mk(4'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        #1;
        got  = observe();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) $display("FAIL mid_async_clear: got %h want %h", got, want);
        else passed++;
        exp_q.push_back(mk(4'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        @(negedge clk);
        got  = observe();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) $display("FAIL mid_no_done: got %h want %h", got, want);
        else passed++;
        @(posedge clk);
        #1 reset = 1'b0;
        req = 4'b0100;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk);
            #1;
            exp_q.push_back(mk(4'b0100, 2'd2, 1'b1, 2'(c - 1), 1'b0, 1'b0));
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) $display("FAIL mid_resume c%0d: got %h want %h", c, got, want);
            else passed++;
        end
    endtask

    task automatic test_early_release();
        obs_t got;
        obs_t want;
        obs_t tbl[5];
`ifdef ARB_EARLY_RELEASE_EN
        tbl[0] = mk(4'b0100, 2'd2, 1'b1, 2'd0, 1'b0, 1'b0);
        tbl[1] = mk(4'b0100, 2'd2, 1'b0, 2'd1, 1'b0, 1'b0);
        tbl[2] = mk(4'b1000, 2'd3, 1'b1, 2'd0, 1'b0, 1'b1);
        tbl[3] = mk(4'b1000, 2'd3, 1'b1, 2'd1, 1'b0, 1'b0);
        tbl[4] = mk(4'b1000, 2'd3, 1'b1, 2'd2, 1'b1, 1'b0);
`else
        tbl[0] = mk(4'b0100, 2'd2, 1'b1, 2'd0, 1'b0, 1'b0);
        tbl[1] = mk(4'b0100, 2'd2, 1'b1, 2'd1, 1'b0, 1'b0);
        tbl[2] = mk(4'b0100, 2'd2, 1'b1, 2'd2, 1'b1, 1'b0);
        tbl[3] = mk(4'b1000, 2'd3, 1'b1, 2'd0, 1'b0, 1'b1);
        tbl[4] = mk(4'b1000, 2'd3, 1'b1, 2'd1, 1'b0, 1'b0);
`endif
        do_reset();
        req = 4'b1100;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) req = 4'b1000;
            exp_q.push_back(tbl[c-1]);
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) $display("FAIL early_release c%0d: got %h want %h", c, got, want);
            else passed++;
        end
    endtask

    task automatic test_single_beat();
        logic [9:0] got;
        logic [9:0] want;
        logic [1:0] id;
        do_reset();
        req2 = 4'b0110;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            id = (c % 2 == 1) ? 2'd1 : 2'd2;
            exp2_q.push_back({4'b0001 << id, id, 1'b1, 1'b0, 1'b1, c > 1});
            @(negedge clk);
            got  = {grant2, grant_id2, beat_valid2, beat_count2, last_beat2, burst_done2};
            want = exp2_q.pop_front();
            checks++;
            if (got !== want) $display("FAIL single_beat c%0d: got %h want %h", c, got, want);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single_requester();
        test_round_robin();
        test_backpressure();
        test_reset_mid_burst();
        test_early_release();
        test_single_beat();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d of %0d checks passed", passed, checks);
        $fatal(1);
    end

endmodule
